insn_pipe_ctrl: RTL and testbench

Owns the four instruction latches (F/D, D/X, X/M, M/W) that carry instructions through the 5-stage pipeline and presents them to the forwarding logic. Detects load-use hazards and inserts bubbles. Flushes on taken branches. Runs the start/ready handshake with the multicycle mult/div unit and stalls the front of the pipe while it is busy.

---
 rtl/insn_pipe_ctrl.sv | 176 +++++++++++++++++
 tb/tb_insn_pipe_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_pipe_ctrl.sv
// Pipeline latch controller: owns F/D, D/X, X/M and M/W, inserts load-use bubbles,
// flushes on taken branches and stalls the front of the pipe around the mult/div handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_RUN     | pipe flows; flush, mult/div start and load-use resolved here
// ST_MD_WAIT | mul/div held in D/X until md_ready or the wait counter expires
module insn_pipe_ctrl #(
    parameter logic [31:0] NOP_INSN   = 32'h0000_0000,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] fetch_insn,
    input  logic        flush,
    input  logic        md_ready,
    output logic [31:0] fd_insn,
    output logic [31:0] dx_insn,
    output logic [31:0] xm_insn,
    output logic [31:0] mw_insn,
    output logic        pc_en,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MD_TIMEOUT);

    typedef enum logic {
        ST_RUN,
        ST_MD_WAIT
    } state_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_FLUSH,
        ACT_MD_HOLD,
        ACT_BUBBLE
    } act_t;

    state_t     state;
    act_t       act;
    logic [7:0] md_count;
    logic       md_expired;
    logic       md_release;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_aluop;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       fd_reads_rs, fd_reads_rt, fd_reads_rd;
    logic       dx_is_muldiv;
    logic       load_use;

    assign fd_op    = fd_insn[31:27];
    assign fd_rd    = fd_insn[26:22];
    assign fd_rs    = fd_insn[21:17];
    assign fd_rt    = fd_insn[16:12];
    assign fd_aluop = fd_insn[6:2];

    assign dx_op    = dx_insn[31:27];
    assign dx_rd    = dx_insn[26:22];
    assign dx_aluop = dx_insn[6:2];

    assign fd_reads_rs = (fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                         (fd_op == OP_SW)    || (fd_op == OP_BNE)  || (fd_op == OP_BLT);
    assign fd_reads_rt = (fd_op == OP_RTYPE) && (fd_aluop != ALU_SLL) && (fd_aluop != ALU_SRL);
    // Store data is forwarded W->M, so sw's rd never needs to stall behind a load.
    assign fd_reads_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);

    assign dx_is_muldiv = (dx_op == OP_RTYPE) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

    assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                      ((fd_reads_rs && (fd_rs == dx_rd)) ||
                       (fd_reads_rt && (fd_rt == dx_rd)) ||
                       (fd_reads_rd && (fd_rd == dx_rd)));

    assign md_expired = (md_count == TIMEOUT_CNT);

    always_comb begin
        act        = ACT_ADVANCE;
        md_release = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush)
                    act = ACT_FLUSH;
                else if (dx_is_muldiv)
                    act = ACT_MD_HOLD;
                else if (load_use)
                    act = ACT_BUBBLE;
            end
            ST_MD_WAIT: begin
                if (md_ready || md_expired) begin
                    act        = ACT_ADVANCE;
                    md_release = 1'b1;
                end else begin
                    act = ACT_MD_HOLD;
                end
            end
            default: act = ACT_ADVANCE;
        endcase
    end

    // Outputs are forced to their idle values while reset is held, whatever the state.
    assign pc_en    = !reset_n || (act == ACT_ADVANCE) || (act == ACT_FLUSH);
    assign md_start = reset_n && (state == ST_RUN) && (act == ACT_MD_HOLD);
    assign md_busy  = reset_n && (state == ST_MD_WAIT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fd_insn    <= NOP_INSN;
            dx_insn    <= NOP_INSN;
            xm_insn    <= NOP_INSN;
            mw_insn    <= NOP_INSN;
            state      <= ST_RUN;
            md_count   <= 8'd0;
            md_timeout <= 1'b0;
        end else begin
            case (act)
                ACT_ADVANCE: begin
                    mw_insn <= xm_insn;
                    xm_insn <= dx_insn;
                    dx_insn <= fd_insn;
                    fd_insn <= fetch_insn;
                end
                ACT_FLUSH: begin
                    mw_insn <= xm_insn;
                    xm_insn <= dx_insn;
                    dx_insn <= NOP_INSN;
                    fd_insn <= NOP_INSN;
                end
                ACT_MD_HOLD: begin
                    mw_insn <= xm_insn;
                    xm_insn <= NOP_INSN;
                end
                ACT_BUBBLE: begin
                    mw_insn <= xm_insn;
                    xm_insn <= dx_insn;
                    dx_insn <= NOP_INSN;
                end
                default: ;
            endcase

            case (state)
                ST_RUN: begin
                    if (act == ACT_MD_HOLD) begin
                        state    <= ST_MD_WAIT;
                        md_count <= 8'd1;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_release) begin
                        state <= ST_RUN;
                        if (!md_ready)
                            md_timeout <= 1'b1;
                    end else begin
                        md_count <= md_count + 8'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_pipe_ctrl.sv
// Scoreboard bench for insn_pipe_ctrl: two instances (MD_TIMEOUT 64 and 4) share stimulus;
// expected values are queued per cycle and compared at the following falling edge.
module tb_insn_pipe_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] LW   = 32'h40C4_0000;  // lw  r3,0(r2)
    localparam logic [31:0] ADD  = 32'h0106_5000;  // add r4,r3,r5
    localparam logic [31:0] SW   = 32'h38CE_0000;  // sw  r3,0(r7)
    localparam logic [31:0] LW0  = 32'h4004_0000;  // lw  r0,0(r2)
    localparam logic [31:0] ADD0 = 32'h0100_5000;  // add r4,r0,r5
    localparam logic [31:0] SLL  = 32'h0100_3010;  // sll r4,r0,r3
    localparam logic [31:0] MUL  = 32'h0182_2018;  // mul r6,r1,r2
    localparam logic [31:0] F1   = 32'h2800_0001;
    localparam logic [31:0] F2   = 32'h2800_0002;
    localparam logic [31:0] F3   = 32'h2800_0003;

    localparam int FD = 0, DX = 1, XM = 2, MW = 3, PC = 4, MS = 5, BZ = 6, TO = 7;
    localparam int B  = 8;

    logic        clock = 1'b0;
    logic        reset_n, flush, md_ready;
    logic [31:0] fetch_insn;

    logic [31:0] fd_a, dx_a, xm_a, mw_a, fd_b, dx_b, xm_b, mw_b;
    logic        pc_en_a, md_start_a, md_busy_a, md_timeout_a;
    logic        pc_en_b, md_start_b, md_busy_b, md_timeout_b;

    always #5 clock = ~clock;

    insn_pipe_ctrl #(.NOP_INSN(32'h0), .MD_TIMEOUT(64)) u_dut (
        .clock(clock), .reset_n(reset_n), .fetch_insn(fetch_insn), .flush(flush),
        .md_ready(md_ready), .fd_insn(fd_a), .dx_insn(dx_a), .xm_insn(xm_a), .mw_insn(mw_a),
        .pc_en(pc_en_a), .md_start(md_start_a), .md_busy(md_busy_a), .md_timeout(md_timeout_a)
    );

    insn_pipe_ctrl #(.NOP_INSN(32'h0), .MD_TIMEOUT(4)) u_dut_to (
        .clock(clock), .reset_n(reset_n), .fetch_insn(fetch_insn), .flush(flush),
        .md_ready(md_ready), .fd_insn(fd_b), .dx_insn(dx_b), .xm_insn(xm_b), .mw_insn(mw_b),
        .pc_en(pc_en_b), .md_start(md_start_b), .md_busy(md_busy_b), .md_timeout(md_timeout_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        logic [31:0] v;
        case (sel)
            FD:     v = fd_a;
            DX:     v = dx_a;
            XM:     v = xm_a;
            MW:     v = mw_a;
            PC:     v = {31'd0, pc_en_a};
            MS:     v = {31'd0, md_start_a};
            BZ:     v = {31'd0, md_busy_a};
            TO:     v = {31'd0, md_timeout_a};
            B+FD:   v = fd_b;
            B+DX:   v = dx_b;
            B+XM:   v = xm_b;
            B+MW:   v = mw_b;
            B+PC:   v = {31'd0, pc_en_b};
            B+MS:   v = {31'd0, md_start_b};
            B+BZ:   v = {31'd0, md_busy_b};
            B+TO:   v = {31'd0, md_timeout_b};
            default: v = 'x;
        endcase
        return v;
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // Compare everything queued for this cycle at the falling edge, then step past the next rise.
    task automatic cyc();
        exp_t e;
        @(negedge clock);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, sample(e.sel), e.val);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; md_ready = 1'b0; fetch_insn = NOP;

        for (int i = 0; i < 2; i++) begin
            want("rst_pc_en", i*B+PC, 1);
            want("rst_md_start", i*B+MS, 0);
            want("rst_md_busy", i*B+BZ, 0);
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            want("rst_fd", i*B+FD, NOP);
            want("rst_dx", i*B+DX, NOP);
            want("rst_xm", i*B+XM, NOP);
            want("rst_mw", i*B+MW, NOP);
            want("rst_pc_en2", i*B+PC, 1);
            want("rst_md_timeout", i*B+TO, 0);
        end
        cyc();
        reset_n = 1'b1;

        // load-use: lw r3 followed by add using r3
        fetch_insn = LW;   want("lu_fd0", FD, NOP); cyc();
        fetch_insn = ADD;  want("lu_fd_lw", FD, LW); want("lu_pc_pre", PC, 1); cyc();
        fetch_insn = F1;   want("lu_stall_pc", PC, 0); want("lu_fd_add", FD, ADD);
                           want("lu_dx_lw", DX, LW); cyc();
        want("lu_hold_fd", FD, ADD); want("lu_bubble_dx", DX, NOP);
        want("lu_xm_lw", XM, LW); want("lu_pc_resume", PC, 1); cyc();
        fetch_insn = LW;   want("lu_dx_add", DX, ADD); want("lu_mw_lw", MW, LW);
                           want("lu_fd_f1", FD, F1); cyc();

        // no stall: sw rd, load to r0, shift's rt
        fetch_insn = SW;   want("sw_fd_lw", FD, LW); cyc();
        fetch_insn = LW0;  want("sw_no_stall", PC, 1); want("sw_dx_lw", DX, LW);
                           want("sw_fd_sw", FD, SW); cyc();
        fetch_insn = ADD0; want("r0_fd_lw0", FD, LW0); cyc();
        fetch_insn = LW;   want("r0_no_stall", PC, 1); want("r0_dx_lw0", DX, LW0);
                           want("r0_fd_add0", FD, ADD0); cyc();
        fetch_insn = SLL;  want("r0_xm_lw0", XM, LW0); want("sll_fd_lw", FD, LW); cyc();
        fetch_insn = F1;   want("sll_no_stall", PC, 1); want("sll_fd", FD, SLL);
                           want("sll_dx_lw", DX, LW); cyc();
        fetch_insn = F2;   want("sll_dx", DX, SLL); want("sll_xm_lw", XM, LW); cyc();

        // flush, plain and against a simultaneous load-use
        flush = 1'b1; fetch_insn = F3;
        want("fl_pc", PC, 1); want("fl_fd_pre", FD, F2); want("fl_dx_pre", DX, F1); cyc();
        flush = 1'b0; fetch_insn = LW;
        want("fl_fd", FD, NOP); want("fl_dx", DX, NOP); want("fl_xm", XM, F1);
        want("fl_mw", MW, SLL); cyc();
        fetch_insn = ADD;  want("fl2_fd_lw", FD, LW); cyc();
        flush = 1'b1; fetch_insn = F1;
        want("fl_lu_pc", PC, 1); want("fl_lu_fd_pre", FD, ADD); want("fl_lu_dx_pre", DX, LW); cyc();
        flush = 1'b0; fetch_insn = MUL;
        want("fl_lu_fd", FD, NOP); want("fl_lu_dx", DX, NOP); want("fl_lu_xm", XM, LW); cyc();

        // mul/div handshake, released by md_ready
        fetch_insn = F1;   want("md_fd_mul", FD, MUL); want("md_no_start", MS, 0); cyc();
        fetch_insn = F2;   want("md_start", MS, 1); want("md_start_pc", PC, 0);
                           want("md_start_busy", BZ, 0); want("md_dx_mul", DX, MUL); cyc();
        for (int i = 0; i < 5; i++) begin
            want("md_wait_start", MS, 0); want("md_wait_busy", BZ, 1);
            want("md_wait_pc", PC, 0); want("md_wait_fd", FD, F1);
            want("md_wait_dx", DX, MUL); want("md_wait_xm", XM, NOP);
            cyc();
        end
        md_ready = 1'b1;   want("md_rel_busy", BZ, 1); want("md_rel_pc", PC, 1); cyc();
        md_ready = 1'b0; fetch_insn = F3;
        want("md_post_xm", XM, MUL); want("md_post_busy", BZ, 0); want("md_post_pc", PC, 1);
        want("md_post_dx", DX, F1); want("md_post_fd", FD, F2); want("md_post_to", TO, 0);
        want("md_post_start", MS, 0); cyc();

        // timeout release on the MD_TIMEOUT=4 instance
        reset_n = 1'b0; fetch_insn = NOP; cyc();
        reset_n = 1'b1; fetch_insn = MUL;
        want("to_rst_fd", B+FD, NOP); want("to_rst_dx", B+DX, NOP); want("to_rst_xm", B+XM, NOP);
        want("to_rst_mw", B+MW, NOP); want("to_rst_clear", B+TO, 0); cyc();
        fetch_insn = F1;   want("to_fd_mul", B+FD, MUL); cyc();
        fetch_insn = F2;   want("to_start", B+MS, 1); want("to_start_pc", B+PC, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            want("to_wait_busy", B+BZ, 1); want("to_wait_pc", B+PC, 0);
            want("to_wait_start", B+MS, 0); want("to_wait_xm", B+XM, NOP);
            want("to_wait_flag", B+TO, 0);
            cyc();
        end
        want("to_last_busy", B+BZ, 1); want("to_release_pc", B+PC, 1); want("to_last_flag", B+TO, 0);
        cyc();
        fetch_insn = F3;
        want("to_post_busy", B+BZ, 0); want("to_flag_set", B+TO, 1); want("to_post_xm", B+XM, MUL);
        want("to_post_dx", B+DX, F1); want("to_post_fd", B+FD, F2);
        want("long_still_busy", BZ, 1); want("long_no_flag", TO, 0); cyc();
        for (int i = 0; i < 2; i++) begin
            want("to_flag_sticky", B+TO, 1); want("long_busy", BZ, 1);
            cyc();
        end

        // reset while the 64-cycle instance is still waiting
        reset_n = 1'b0;
        want("rw_in_rst_pc", PC, 1); want("rw_in_rst_busy", BZ, 0); want("rw_in_rst_start", MS, 0);
        cyc();
        reset_n = 1'b1; fetch_insn = F1;
        want("rw_fd", FD, NOP); want("rw_dx", DX, NOP); want("rw_xm", XM, NOP); want("rw_mw", MW, NOP);
        want("rw_busy", BZ, 0); want("rw_to", TO, 0); want("rw_pc", PC, 1); want("rw_start", MS, 0);
        want("rw_to_flag_clear", B+TO, 0); cyc();
        want("rw_fd_f1", FD, F1); want("rw_no_restart", MS, 0); want("rw_busy2", BZ, 0); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
